// File: rtl/wb_burst_master_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wb_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone initiator/responder bundle between the burst master and the SDRAM controller.
interface wb_burst_master_if #(
  parameter int DW = 32,
  parameter int AW = 26
);

  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );

endinterface

// File: rtl/wb_burst_master_wb_ack_watchdog.sv
// Ack watchdog: counts strobed cycles that get no ack; expired marks the final allowed one.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Wait-cycle counter, restarted by each accepted beat and outside transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Terminal count reached
  always_comb begin
    expired = (count == LAST);
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: turns valid/ready commands into classic or incrementing bursts.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_resetn,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [DW-1:0]     wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DW-1:0]     rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  wb_burst_master_if.master wb
);

  state_t          state;
  logic            armed;
  logic            we;
  logic            single;
  logic            abort;
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] sel;
  logic [LENW-1:0] remaining;

  logic xfer;
  logic stb;
  logic beat_ack;
  logic last_beat;
  logic wd_clear;
  logic wd_enable;
  logic expired;

  // Beat qualification; write strobe follows the data stream so starvation inserts wait states
  always_comb begin
    xfer      = (state == XFER);
    stb       = xfer && (!we || wdata_valid);
    beat_ack  = stb && wb.wb_ack_i;
    last_beat = (remaining == '0);
    wd_clear  = !xfer || beat_ack;
    wd_enable = stb && !wb.wb_ack_i;
  end

  wb_ack_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst_n   (wb_resetn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );

  // Output decode from registered state; armed keeps cmd_ready low while in reset
  always_comb begin
    cmd_ready    = armed && (state == IDLE) && sdr_init_done;
    wdata_ready  = beat_ack && we;
    done         = (state == DONE);
    err          = (state == DONE) && abort;
    wb.wb_cyc_o  = xfer;
    wb.wb_stb_o  = stb;
    wb.wb_we_o   = we;
    wb.wb_addr_o = addr;
    wb.wb_sel_o  = sel;
    wb.wb_dat_o  = (xfer && we) ? wdata : '0;
    if (!xfer || single) begin
      wb.wb_cti_o = CTI_CLASSIC;
    end else if (last_beat) begin
      wb.wb_cti_o = CTI_EOB;
    end else begin
      wb.wb_cti_o = CTI_INCR;
    end
  end

  // Command FSM with address and beat counters
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state     <= IDLE;
      armed     <= 1'b0;
      we        <= 1'b0;
      single    <= 1'b0;
      abort     <= 1'b0;
      addr      <= '0;
      sel       <= '0;
      remaining <= '0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            we        <= cmd_we;
            addr      <= cmd_addr;
            sel       <= cmd_sel;
            remaining <= cmd_len;
            single    <= (cmd_len == '0);
            abort     <= 1'b0;
            state     <= XFER;
          end
        end
        XFER: begin
          // A beat that is acked in the watchdog's final cycle still completes normally
          if (beat_ack) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (last_beat) begin
              state <= DONE;
            end
          end else if (stb && expired) begin
            abort <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data path, one cycle behind the ack
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata       <= wb.wb_dat_i;
      rdata_valid <= beat_ack && !we;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: command table, Wishbone responder model, beat scoreboard.
module tb_wb_burst_master;
  import wb_master_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 26;
  localparam int LENW = 8;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [3:0]      cmd_sel;
  logic [DW-1:0]   wdata;
  logic            wdata_valid;
  logic            wdata_ready;
  logic [DW-1:0]   rdata;
  logic            rdata_valid;
  logic            done;
  logic            err;

  wb_burst_master_if #(.DW(DW), .AW(AW)) wb ();

  wb_burst_master #(
    .DW(DW), .AW(AW), .LENW(LENW), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i      (clk),
    .wb_resetn     (rst_n),
    .sdr_init_done (init),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_sel       (cmd_sel),
    .wdata         (wdata),
    .wdata_valid   (wdata_valid),
    .wdata_ready   (wdata_ready),
    .rdata         (rdata),
    .rdata_valid   (rdata_valid),
    .done          (done),
    .err           (err),
    .wb            (wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [LENW-1:0] len;
    logic [3:0]      sel;
    int              wait_n;
    int              starve_beat;
    int              starve_n;
    logic            spur;
    logic            never;
    int              init_delay;
    logic [31:0]     base;
    int              exp_len;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  logic        cur_we = 1'b0;

  // Responder model state
  int          slv_wait  = 0;
  int          slv_cnt   = 0;
  int          slv_beat  = 0;
  logic        slv_never = 1'b0;
  logic        slv_spur  = 1'b0;
  logic [31:0] slv_base  = '0;

  // Responder: decides ack for the current cycle once the master's strobe has settled
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      wb.wb_ack_i = 1'b0;
      slv_cnt     = 0;
    end else if (wb.wb_cyc_o && wb.wb_stb_o) begin
      if (!slv_never && slv_cnt >= slv_wait) begin
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = slv_base + 32'(slv_beat);
        slv_beat++;
        slv_cnt = 0;
      end else begin
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = $urandom;
        slv_cnt++;
      end
    end else begin
      wb.wb_ack_i = slv_spur && wb.wb_cyc_o;
      wb.wb_dat_i = $urandom;
    end
  end

  // Scoreboard: compares every accepted beat and every read-data word against queued expectations
  logic  prev_rd_ack = 1'b0;
  beat_t e;
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_rd_ack = 1'b0;
    end else begin
      if (rdata_valid || prev_rd_ack) check("rdata_valid one cycle after read ack", rdata_valid, prev_rd_ack);
      if (rdata_valid) begin
        check("rdata queue nonempty", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("rdata value", rdata, rd_q.pop_front());
      end
      if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i) begin
        check("beat queue nonempty", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          e = beat_q.pop_front();
          check("beat addr", wb.wb_addr_o, e.addr);
          check("beat cti", wb.wb_cti_o, e.cti);
          check("beat we", wb.wb_we_o, e.we);
          check("beat sel", wb.wb_sel_o, e.sel);
          if (e.we) check("beat wdata", wb.wb_dat_o, e.dat);
        end
      end
      prev_rd_ack = wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i && !cur_we;
    end
  end

  // Present a command (optionally with init held low first) and queue its expected beats
  task automatic start_cmd(input vec_t v);
    logic [AW-1:0] a;
    @(negedge clk);
    init        = (v.init_delay == 0);
    cmd_valid   = 1'b1;
    cmd_we      = v.we;
    cmd_addr    = v.addr;
    cmd_len     = v.len;
    cmd_sel     = v.sel;
    wdata_valid = 1'b0;
    slv_wait    = v.wait_n;
    slv_never   = v.never;
    slv_spur    = v.spur;
    slv_base    = v.base;
    slv_beat    = 0;
    slv_cnt     = 0;
    cur_we      = v.we;
    if (!v.never) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        beat_t b;
        a      = v.addr + AW'(i);
        b.addr = a;
        b.cti  = (v.len == 0) ? CTI_CLASSIC : ((i == int'(v.len)) ? CTI_EOB : CTI_INCR);
        b.we   = v.we;
        b.dat  = v.base + 32'(i);
        b.sel  = v.sel;
        beat_q.push_back(b);
        if (!v.we) rd_q.push_back(v.base + 32'(i));
      end
    end
    for (int d = 0; d < v.init_delay; d++) begin
      #2;
      check("cmd_ready low while init low", cmd_ready, 0);
      check("no cyc while init low", wb.wb_cyc_o, 0);
      @(negedge clk);
    end
    init = 1'b1;
    #2;
    check("cmd_ready at accept", cmd_ready, 1);
  endtask

  // Run one command to completion and check latency, abort status and the idle cycle after it
  task automatic run_cmd(input vec_t v, input int idx);
    int n      = 0;
    int cyc_n  = 0;
    int wbeat  = 0;
    int starved = 0;
    start_cmd(v);
    while (n < 300) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (v.we && wbeat <= int'(v.len)) begin
        if (wbeat == v.starve_beat - 1 && starved < v.starve_n) begin
          wdata_valid = 1'b0;
          wdata       = ~v.base;
          starved++;
        end else begin
          wdata_valid = 1'b1;
          wdata       = v.base + 32'(wbeat);
        end
      end else begin
        wdata_valid = 1'b0;
      end
      #2;
      n++;
      if (wb.wb_cyc_o) cyc_n++;
      if (wdata_ready) wbeat++;
      if (done) break;
    end
    check($sformatf("v%0d done seen", idx), done, 1);
    check($sformatf("v%0d done latency", idx), n, v.exp_len + 1);
    check($sformatf("v%0d cyc cycles", idx), cyc_n, v.exp_len);
    check($sformatf("v%0d err", idx), err, v.exp_err);
    if (v.we && !v.never) check($sformatf("v%0d write beats taken", idx), wbeat, int'(v.len) + 1);
    @(negedge clk);
    wdata_valid = 1'b0;
    #2;
    check($sformatf("v%0d done one cycle", idx), done, 0);
    check($sformatf("v%0d err one cycle", idx), err, 0);
    check($sformatf("v%0d cyc idle", idx), wb.wb_cyc_o, 0);
    check($sformatf("v%0d cti idle", idx), wb.wb_cti_o, CTI_CLASSIC);
    check($sformatf("v%0d cmd_ready back", idx), cmd_ready, 1);
    check($sformatf("v%0d beats left", idx), beat_q.size(), 0);
    check($sformatf("v%0d rdata left", idx), rd_q.size(), 0);
  endtask

  vec_t vecs[8];
  vec_t r;

  initial begin
    // we addr len sel wait starve_beat starve_n spur never init_delay base exp_len exp_err
    vecs[0] = '{1'b1, 26'h0000100, 8'd0, 4'hF, 2,  0, 0,  1'b0, 1'b0, 0, 32'hDEADBEEF, 3,  1'b0};
    vecs[1] = '{1'b0, 26'h3FFFFFE, 8'd7, 4'hF, 0,  0, 0,  1'b0, 1'b0, 0, 32'h00000010, 8,  1'b0};
    vecs[2] = '{1'b1, 26'h0002000, 8'd3, 4'h3, 0,  3, 3,  1'b0, 1'b0, 0, 32'hA5A50000, 7,  1'b0};
    vecs[3] = '{1'b1, 26'h0003000, 8'd3, 4'hC, 1,  2, 20, 1'b1, 1'b0, 0, 32'h5A5A0000, 28, 1'b0};
    vecs[4] = '{1'b0, 26'h0000040, 8'd3, 4'hF, 0,  0, 0,  1'b0, 1'b1, 0, 32'h00000000, 16, 1'b1};
    vecs[5] = '{1'b0, 26'h0000055, 8'd0, 4'hF, 1,  0, 0,  1'b0, 1'b0, 3, 32'h00000077, 2,  1'b0};
    vecs[6] = '{1'b1, 26'h3FFFFFF, 8'd1, 4'hA, 3,  0, 0,  1'b0, 1'b0, 0, 32'h12340000, 8,  1'b0};
    vecs[7] = '{1'b0, 26'h0000800, 8'd1, 4'hF, 15, 0, 0,  1'b0, 1'b0, 0, 32'h00000900, 32, 1'b0};

    rst_n       = 1'b0;
    init        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    cmd_sel     = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    #3;
    check("reset cyc", wb.wb_cyc_o, 0);
    check("reset stb", wb.wb_stb_o, 0);
    check("reset cti", wb.wb_cti_o, 0);
    check("reset addr", wb.wb_addr_o, 0);
    check("reset sel", wb.wb_sel_o, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset rdata_valid", rdata_valid, 0);
    check("reset cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], i);

    // Reset asserted during beat 3 of an 8-beat read burst
    r      = vecs[1];
    r.addr = 26'h0000100;
    r.base = 32'h00000200;
    start_cmd(r);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("mid-burst cyc before reset", wb.wb_cyc_o, 1);
    check("mid-burst addr beat 3", wb.wb_addr_o, 26'h0000102);
    rst_n = 1'b0;
    #1;
    check("async reset cyc", wb.wb_cyc_o, 0);
    check("async reset stb", wb.wb_stb_o, 0);
    check("async reset cti", wb.wb_cti_o, 0);
    check("async reset addr", wb.wb_addr_o, 0);
    check("async reset we", wb.wb_we_o, 0);
    check("async reset rdata_valid", rdata_valid, 0);
    check("async reset rdata", rdata, 0);
    check("async reset cmd_ready", cmd_ready, 0);
    repeat (2) begin
      @(negedge clk);
      #2;
      check("no done in reset", done, 0);
      check("no err in reset", err, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    beat_q.delete();
    rd_q.delete();
    repeat (2) begin
      @(negedge clk);
      #2;
      check("no done after release", done, 0);
      check("idle after release", wb.wb_cyc_o, 0);
    end
    run_cmd(vecs[1], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "time limit");
  end

endmodule
